// File: rtl/can_rx_collector_if.sv
// rtl/can_rx_collector_if.sv - output stream bundle for the CAN receive collector
interface can_rx_collector_if #(
   parameter int DATA_SIZE = 64,
   parameter int ID_SIZE   = 11,
   parameter int NODE_W    = 2
);
   logic                 out_valid;
   logic                 out_ready;
   logic [DATA_SIZE-1:0] out_packet;
   logic [NODE_W-1:0]    out_node;
   logic [ID_SIZE-1:0]   out_id;

   // Collector side: presents the FIFO head, observes consumer acceptance
   modport master (
      output out_valid,
      output out_packet,
      output out_node,
      output out_id,
      input  out_ready
   );

   // Consumer side: the output pipe sender
   modport slave (
      input  out_valid,
      input  out_packet,
      input  out_node,
      input  out_id,
      output out_ready
   );
endinterface

// File: rtl/can_rx_collector.sv
// rtl/can_rx_collector.sv - per-node pending slots, round-robin arbiter and output FIFO
module can_rx_collector #(
   parameter int TOTAL_NODES = 4,
   parameter int DATA_SIZE   = 64,
   parameter int ID_SIZE     = 11,
   parameter int FIFO_DEPTH  = 8,
   parameter int NODE_W      = $clog2(TOTAL_NODES)
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic [TOTAL_NODES-1:0]           data_out_req,
   input  logic [TOTAL_NODES*DATA_SIZE-1:0] rx_packet,
   input  logic [TOTAL_NODES*ID_SIZE-1:0]   rx_id,
   can_rx_collector_if.master               out_if,
   output logic [$clog2(FIFO_DEPTH):0]      fifo_count,
   output logic [15:0]                      drop_count,
   output logic                             drop_pulse
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   // FIFO entry layout: {packet, id, node}
   localparam int EW = DATA_SIZE + ID_SIZE + NODE_W;

   // Pending slots, one per node
   logic [TOTAL_NODES-1:0] pend_q, pend_d;
   logic [DATA_SIZE-1:0]   slot_pkt_q [TOTAL_NODES];
   logic [DATA_SIZE-1:0]   slot_pkt_d [TOTAL_NODES];
   logic [ID_SIZE-1:0]     slot_id_q  [TOTAL_NODES];
   logic [ID_SIZE-1:0]     slot_id_d  [TOTAL_NODES];

   // Arbiter pointer
   logic [NODE_W-1:0]      rr_ptr_q, rr_ptr_d;

   // FIFO storage and pointers
   logic [EW-1:0]          mem_q [FIFO_DEPTH];
   logic [EW-1:0]          mem_d [FIFO_DEPTH];
   logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]          count_q, count_d;

   // Drop accounting
   logic [15:0]            drop_count_q, drop_count_d;
   logic                   drop_pulse_q, drop_pulse_d;

   // Combinational helpers
   logic                   gnt_found;
   logic [NODE_W-1:0]      gnt_idx;
   logic [NODE_W-1:0]      cand;
   logic                   head_valid;
   logic                   pop;
   logic                   push;
   logic                   can_accept;
   logic [EW-1:0]          head;
   logic [EW-1:0]          push_entry;
   int                     drop_n;
   logic [16:0]            drop_sum;

   assign head_valid = (count_q != '0);
   assign pop        = head_valid && out_if.out_ready;
   // A full FIFO still accepts when the head leaves in the same cycle
   assign can_accept = (count_q < CW'(FIFO_DEPTH)) || pop;
   assign push       = gnt_found && can_accept;
   assign head       = mem_q[rd_ptr_q];
   assign push_entry = {slot_pkt_q[gnt_idx], slot_id_q[gnt_idx], gnt_idx};

   // Round-robin search of pending slots starting at rr_ptr
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int k = 0; k < TOTAL_NODES; k++) begin
         cand = NODE_W'((int'(rr_ptr_q) + k) % TOTAL_NODES);
         if (!gnt_found && pend_q[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   // Slot capture, grant release and drop detection
   always_comb begin
      pend_d     = pend_q;
      slot_pkt_d = slot_pkt_q;
      slot_id_d  = slot_id_q;
      drop_n     = 0;
      for (int i = 0; i < TOTAL_NODES; i++) begin
         if (data_out_req[i]) begin
            if (pend_q[i] && !(push && gnt_idx == NODE_W'(i))) begin
               // Slot still occupied: keep the older packet, lose the new one
               drop_n = drop_n + 1;
            end else begin
               pend_d[i]     = 1'b1;
               slot_pkt_d[i] = rx_packet[i*DATA_SIZE +: DATA_SIZE];
               slot_id_d[i]  = rx_id[i*ID_SIZE +: ID_SIZE];
            end
         end else if (push && gnt_idx == NODE_W'(i)) begin
            pend_d[i] = 1'b0;
         end
      end
   end

   // Saturating drop counter and one-cycle drop strobe
   always_comb begin
      drop_sum     = {1'b0, drop_count_q} + 17'(drop_n);
      drop_count_d = (drop_sum > 17'h0FFFF) ? 16'hFFFF : drop_sum[15:0];
      drop_pulse_d = (drop_n != 0);
   end

   // Arbiter pointer advances past the winner only on a real grant
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (push) begin
         rr_ptr_d = (gnt_idx == NODE_W'(TOTAL_NODES - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

   // FIFO pointers, occupancy and storage write
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CW'(push) - CW'(pop);
      if (push) begin
         mem_d[wr_ptr_q] = push_entry;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   // Control state register with synchronous reset
   always_ff @(posedge clock) begin
      if (reset) begin
         pend_q       <= '0;
         rr_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         drop_count_q <= '0;
         drop_pulse_q <= 1'b0;
      end else begin
         pend_q       <= pend_d;
         rr_ptr_q     <= rr_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         drop_count_q <= drop_count_d;
         drop_pulse_q <= drop_pulse_d;
      end
   end

   // Data storage needs no reset; validity is tracked by pend and count
   always_ff @(posedge clock) begin
      slot_pkt_q <= slot_pkt_d;
      slot_id_q  <= slot_id_d;
      mem_q      <= mem_d;
   end

   // Head outputs are forced to zero while the FIFO is empty
   always_comb begin
      out_if.out_valid  = head_valid;
      out_if.out_packet = '0;
      out_if.out_id     = '0;
      out_if.out_node   = '0;
      if (head_valid) begin
         out_if.out_packet = head[EW-1 -: DATA_SIZE];
         out_if.out_id     = head[NODE_W +: ID_SIZE];
         out_if.out_node   = head[NODE_W-1:0];
      end
   end

   assign fifo_count = count_q;
   assign drop_count = drop_count_q;
   assign drop_pulse = drop_pulse_q;

endmodule

// File: tb/tb_can_rx_collector.sv
// tb/tb_can_rx_collector.sv - directed self-checking bench for can_rx_collector
module tb_can_rx_collector;

   logic         clock = 1'b0;
   logic         reset;
   logic [3:0]   data_out_req;
   logic [255:0] rx_packet;
   logic [43:0]  rx_id;
   logic [3:0]   fifo_count;
   logic [15:0]  drop_count;
   logic         drop_pulse;
   int           total = 0;
   int           bad = 0;

   can_rx_collector_if #(.DATA_SIZE(64), .ID_SIZE(11), .NODE_W(2)) bus ();

   can_rx_collector #(
      .TOTAL_NODES(4), .DATA_SIZE(64), .ID_SIZE(11), .FIFO_DEPTH(8)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .data_out_req (data_out_req),
      .rx_packet    (rx_packet),
      .rx_id        (rx_id),
      .out_if       (bus),
      .fifo_count   (fifo_count),
      .drop_count   (drop_count),
      .drop_pulse   (drop_pulse)
   );

   always #5 clock = ~clock;

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_req(input int node, input logic [63:0] p, input logic [10:0] id);
      data_out_req[node]       = 1'b1;
      rx_packet[node*64 +: 64] = p;
      rx_id[node*11 +: 11]     = id;
   endtask

   task automatic do_reset();
      reset          = 1'b1;
      data_out_req   = '0;
      bus.out_ready  = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset         = 1'b1;
      bus.out_ready = 1'b0;
      data_out_req  = 4'b1111;
      rx_packet     = {4{64'hDEAD_BEEF_0000_0001}};
      rx_id         = {4{11'h7FF}};
      tick();
      tick();
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %0b want 0", bus.out_valid); end
      total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
      total++; if (drop_count !== 16'd0) begin bad++; $display("FAIL rst_drops: got %0d want 0", drop_count); end
      total++; if (drop_pulse !== 1'b0) begin bad++; $display("FAIL rst_pulse: got %0b want 0", drop_pulse); end
      total++; if (bus.out_packet !== 64'd0 || bus.out_node !== 2'd0 || bus.out_id !== 11'd0) begin
         bad++; $display("FAIL rst_head: got %h/%0d/%h want 0/0/0", bus.out_packet, bus.out_node, bus.out_id);
      end
      reset        = 1'b0;
      data_out_req = '0;
      tick();
      tick();
      tick();
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_req_ignored: got %0b want 0", bus.out_valid); end
   endtask

   task automatic test_single();
      do_reset();
      tick();
      tick();
      tick();
      set_req(1, 64'hA5A5_0000_1234_5678, 11'h123);
      tick();
      data_out_req = '0;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_lat1: got %0b want 0", bus.out_valid); end
      tick();
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL single_lat2: got %0b want 1", bus.out_valid); end
      total++; if (bus.out_node !== 2'd1) begin bad++; $display("FAIL single_node: got %0d want 1", bus.out_node); end
      total++; if (bus.out_id !== 11'h123) begin bad++; $display("FAIL single_id: got %h want 123", bus.out_id); end
      total++; if (bus.out_packet !== 64'hA5A5_0000_1234_5678) begin bad++; $display("FAIL single_pkt: got %h want a5a5000012345678", bus.out_packet); end
      total++; if (fifo_count !== 4'd1) begin bad++; $display("FAIL single_count: got %0d want 1", fifo_count); end
      bus.out_ready = 1'b1;
      tick();
      total++; if (fifo_count !== 4'd0 || bus.out_valid !== 1'b0) begin
         bad++; $display("FAIL single_pop: got count=%0d valid=%0b want 0/0", fifo_count, bus.out_valid);
      end
      bus.out_ready = 1'b0;
   endtask

   task automatic test_simultaneous();
      do_reset();
      for (int i = 0; i < 4; i++) set_req(i, 64'hC0DE_0000_0000_0000 + 64'(i), 11'h100 + 11'(i));
      tick();
      data_out_req  = '0;
      bus.out_ready = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         total++; if (bus.out_valid !== 1'b1 || bus.out_node !== 2'(i) || bus.out_packet !== 64'hC0DE_0000_0000_0000 + 64'(i)
                      || bus.out_id !== 11'h100 + 11'(i)) begin
            bad++; $display("FAIL simul_order%0d: got v=%0b node=%0d pkt=%h want 1/%0d", i, bus.out_valid, bus.out_node, bus.out_packet, i);
         end
         tick();
      end
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL simul_empty: got %0b want 0", bus.out_valid); end
      total++; if (drop_count !== 16'd0) begin bad++; $display("FAIL simul_drops: got %0d want 0", drop_count); end
      // rr_ptr must have wrapped to 0: node 0 beats node 3
      set_req(3, 64'h3333, 11'h033);
      set_req(0, 64'h0000_0000_0000_0F00, 11'h030);
      tick();
      data_out_req = '0;
      tick();
      total++; if (bus.out_node !== 2'd0) begin bad++; $display("FAIL simul_rr_wrap_first: got %0d want 0", bus.out_node); end
      tick();
      total++; if (bus.out_node !== 2'd3) begin bad++; $display("FAIL simul_rr_wrap_second: got %0d want 3", bus.out_node); end
      tick();
      bus.out_ready = 1'b0;
   endtask

   task automatic test_rr_fairness();
      do_reset();
      bus.out_ready = 1'b1;
      set_req(2, 64'h2222_2222_2222_2222, 11'h222);
      tick();
      data_out_req = '0;
      tick();
      total++; if (bus.out_node !== 2'd2 || bus.out_valid !== 1'b1) begin bad++; $display("FAIL rr_first: got node=%0d want 2", bus.out_node); end
      tick();
      set_req(0, 64'h0A0A_0A0A_0A0A_0A0A, 11'h0AA);
      set_req(3, 64'h3B3B_3B3B_3B3B_3B3B, 11'h3BB);
      tick();
      data_out_req = '0;
      tick();
      total++; if (bus.out_node !== 2'd3 || bus.out_packet !== 64'h3B3B_3B3B_3B3B_3B3B) begin
         bad++; $display("FAIL rr_node3_first: got node=%0d pkt=%h want 3", bus.out_node, bus.out_packet);
      end
      tick();
      total++; if (bus.out_node !== 2'd0 || bus.out_id !== 11'h0AA) begin
         bad++; $display("FAIL rr_node0_second: got node=%0d id=%h want 0/0aa", bus.out_node, bus.out_id);
      end
      tick();
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rr_empty: got %0b want 0", bus.out_valid); end
      bus.out_ready = 1'b0;
   endtask

   task automatic test_push_pop_full();
      do_reset();
      for (int k = 1; k <= 8; k++) begin
         set_req(0, 64'hF000 + 64'(k), 11'(k));
         tick();
      end
      data_out_req = '0;
      tick();
      total++; if (fifo_count !== 4'd8) begin bad++; $display("FAIL ppf_full: got %0d want 8", fifo_count); end
      set_req(1, 64'hB1B1_B1B1_0000_0001, 11'h1B1);
      tick();
      data_out_req = '0;
      total++; if (fifo_count !== 4'd8 || bus.out_packet !== 64'hF001) begin
         bad++; $display("FAIL ppf_hold: got count=%0d pkt=%h want 8/f001", fifo_count, bus.out_packet);
      end
      bus.out_ready = 1'b1;
      tick();
      total++; if (fifo_count !== 4'd8) begin bad++; $display("FAIL ppf_count_same: got %0d want 8", fifo_count); end
      total++; if (drop_pulse !== 1'b0 || drop_count !== 16'd0) begin
         bad++; $display("FAIL ppf_nodrop: got pulse=%0b drops=%0d want 0/0", drop_pulse, drop_count);
      end
      for (int k = 2; k <= 8; k++) begin
         total++; if (bus.out_valid !== 1'b1 || bus.out_node !== 2'd0 || bus.out_packet !== 64'hF000 + 64'(k)) begin
            bad++; $display("FAIL ppf_drain%0d: got node=%0d pkt=%h want 0/%h", k, bus.out_node, bus.out_packet, 64'hF000 + 64'(k));
         end
         tick();
      end
      total++; if (bus.out_node !== 2'd1 || bus.out_packet !== 64'hB1B1_B1B1_0000_0001 || bus.out_id !== 11'h1B1) begin
         bad++; $display("FAIL ppf_last: got node=%0d pkt=%h want 1/b1b1b1b100000001", bus.out_node, bus.out_packet);
      end
      tick();
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL ppf_empty: got %0b want 0", bus.out_valid); end
      bus.out_ready = 1'b0;
   endtask

   task automatic test_full_drop();
      do_reset();
      for (int k = 1; k <= 9; k++) begin
         set_req(0, 64'h5000_0000_0000_0000 + 64'(k), 11'h500 + 11'(k));
         tick();
      end
      data_out_req = '0;
      total++; if (fifo_count !== 4'd8) begin bad++; $display("FAIL fd_full: got %0d want 8", fifo_count); end
      total++; if (drop_count !== 16'd0) begin bad++; $display("FAIL fd_nodrop_yet: got %0d want 0", drop_count); end
      set_req(0, 64'hDEAD_DEAD_DEAD_DEAD, 11'h7DD);
      tick();
      data_out_req = '0;
      total++; if (drop_pulse !== 1'b1) begin bad++; $display("FAIL fd_pulse: got %0b want 1", drop_pulse); end
      total++; if (drop_count !== 16'd1) begin bad++; $display("FAIL fd_count: got %0d want 1", drop_count); end
      tick();
      total++; if (drop_pulse !== 1'b0) begin bad++; $display("FAIL fd_pulse_clear: got %0b want 0", drop_pulse); end
      bus.out_ready = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         total++; if (bus.out_valid !== 1'b1 || bus.out_packet !== 64'h5000_0000_0000_0000 + 64'(k)
                      || bus.out_id !== 11'h500 + 11'(k)) begin
            bad++; $display("FAIL fd_order%0d: got v=%0b pkt=%h want 1/%h", k, bus.out_valid, bus.out_packet, 64'h5000_0000_0000_0000 + 64'(k));
         end
         tick();
      end
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL fd_empty: got %0b want 0", bus.out_valid); end
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      // Starts with drop_count=1 carried over from the drop scenario
      for (int k = 1; k <= 5; k++) begin
         set_req(0, 64'h6000 + 64'(k), 11'(k));
         tick();
      end
      data_out_req = '0;
      set_req(1, 64'h6111, 11'h611);
      set_req(2, 64'h6222, 11'h622);
      tick();
      data_out_req = '0;
      total++; if (fifo_count !== 4'd5 || drop_count !== 16'd1) begin
         bad++; $display("FAIL rm_pre: got count=%0d drops=%0d want 5/1", fifo_count, drop_count);
      end
      set_req(0, 64'hBAD0, 11'h0BD);
      reset = 1'b1;
      tick();
      reset        = 1'b0;
      data_out_req = '0;
      total++; if (bus.out_valid !== 1'b0 || fifo_count !== 4'd0 || drop_count !== 16'd0) begin
         bad++; $display("FAIL rm_cleared: got v=%0b count=%0d drops=%0d want 0/0/0", bus.out_valid, fifo_count, drop_count);
      end
      tick();
      tick();
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rm_pend_cleared: got %0b want 0", bus.out_valid); end
      set_req(3, 64'h7777_0000_0000_0003, 11'h377);
      tick();
      data_out_req = '0;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rm_lat1: got %0b want 0", bus.out_valid); end
      tick();
      total++; if (bus.out_valid !== 1'b1 || bus.out_node !== 2'd3 || bus.out_packet !== 64'h7777_0000_0000_0003) begin
         bad++; $display("FAIL rm_fresh: got v=%0b node=%0d pkt=%h want 1/3/7777000000000003", bus.out_valid, bus.out_node, bus.out_packet);
      end
   endtask

   initial begin
      reset         = 1'b1;
      data_out_req  = '0;
      rx_packet     = '0;
      rx_id         = '0;
      bus.out_ready = 1'b0;
      test_reset();
      test_single();
      test_simultaneous();
      test_rr_fairness();
      test_push_pop_full();
      test_full_drop();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/can_rx_collector.md
Name: can_rx_collector

Overview:
- Downstream of the CAN node array in the HDL-side transactor. Collects received packets from all nodes and forwards them one at a time to the single-element SCE-MI output pipe sender.
- Each node raises a one-cycle data_out_req when it accepts a frame. Several nodes may do so in the same cycle.
- The block buffers each request in a per-node pending slot, then round-robin arbitrates the slots into a FIFO. The FIFO head is presented on a valid/ready interface.
- Tags every packet with its source node and Rx identifier. Counts packets dropped on overflow for the end-of-run scoreboard.

Parameters:
- TOTAL_NODES, 4, number of CAN nodes feeding the block (≥2).
- DATA_SIZE, 64, packet width in bits.
- ID_SIZE, 11, CAN identifier width.
- FIFO_DEPTH, 8, FIFO entries (power of 2).
- NODE_W, $clog2(TOTAL_NODES), node index width.

Ports:
- clock, in, 1, system clock.
- reset, in, 1, synchronous, active-high.
- data_out_req, in, TOTAL_NODES, per-node one-cycle "packet received" strobe.
- rx_packet, in, TOTAL_NODES*DATA_SIZE, node i data in bits [i*DATA_SIZE +: DATA_SIZE].
- rx_id, in, TOTAL_NODES*ID_SIZE, node i acceptance ID in bits [i*ID_SIZE +: ID_SIZE].
- out_valid, out, 1, FIFO head valid.
- out_ready, in, 1, consumer accepts head.
- out_packet, out, DATA_SIZE, head packet.
- out_node, out, NODE_W, head source node.
- out_id, out, ID_SIZE, head Rx ID.
- fifo_count, out, $clog2(FIFO_DEPTH)+1, current FIFO occupancy.
- drop_count, out, 16, saturating count of dropped packets.
- drop_pulse, out, 1, one-cycle strobe on each drop.

Behaviour:
- Reset, applied at any time including mid-operation:
  - Clears all pending slots and FIFO pointers, fifo_count=0, rr_ptr=0.
  - out_valid=0, out_packet/out_node/out_id=0, drop_count=0, drop_pulse=0.
  - data_out_req is ignored in reset cycles.
- Capture:
  - On a clock edge where data_out_req[i]=1, slot i loads {rx_packet[i], rx_id[i]} and pend[i] is set.
  - If pend[i] is already set and slot i is not granted in that same cycle, the new packet is dropped. drop_pulse=1 next cycle; drop_count increments, saturating at 16'hFFFF. The old slot content is kept.
  - If slot i is granted in the same cycle it is re-requested, the slot reloads with no drop.
- Arbitration, one grant per cycle:
  - Search pend[] starting at rr_ptr, ascending, wrapping modulo TOTAL_NODES.
  - First set bit g wins, if the FIFO can accept.
  - On grant: write {slot g, g} to the FIFO tail, clear pend[g] (unless reloaded), rr_ptr=(g+1)%TOTAL_NODES.
  - No grant: rr_ptr unchanged.
- FIFO:
  - Can accept when fifo_count<FIFO_DEPTH, or when fifo_count==FIFO_DEPTH and a pop occurs the same cycle.
  - Pop when out_valid && out_ready.
  - Simultaneous push and pop leaves fifo_count unchanged.
  - Pointers wrap at FIFO_DEPTH.
  - out_valid = (fifo_count!=0). Outputs come from registered storage; no combinational path from inputs to outputs.
  - out_ready while out_valid=0 has no effect.
  - While out_valid=1 && out_ready=0, head outputs hold stable.
- Latency: data_out_req high in cycle t on an idle block gives out_valid=1 in cycle t+2.
- Backpressure: with the FIFO full, pending slots hold. Drops occur only when a node re-requests while its slot is still pending.
- Ordering:
  - Per node, packets emerge in request order.
  - Across nodes requesting in the same cycle, round-robin order starting at rr_ptr.
- Throughput: one packet per cycle sustained when out_ready=1.

Test Plan:
- Single request: reset, then data_out_req=4'b0010, rx_packet[1]=64'hA5A5_0000_1234_5678, rx_id[1]=11'h123 in cycle 5 -> out_valid=1 in cycle 7 with out_node=1, out_id=11'h123, that packet; fifo_count=1; pop with out_ready=1 -> fifo_count=0.
- Simultaneous requests: data_out_req=4'b1111 in one cycle, rr_ptr=0, out_ready=1 -> outputs nodes 0,1,2,3 on consecutive cycles; rr_ptr ends at 0; drop_count=0.
- Round-robin fairness: after a grant to node 2, nodes 0 and 3 request together -> node 3 emitted first, then node 0.
- Full and drop: out_ready=0, 9 requests from node 0 on separate cycles (DEPTH=8) -> fifo_count=8, slot 0 pending. A 10th request from node 0 -> drop_pulse one cycle, drop_count=1. Then out_ready=1 -> 9 packets emerge in order.
- Push/pop at full: fifo_count=8, out_ready=1, node 1 pending -> the same cycle pops and pushes; fifo_count stays 8; no drop.
- Reset mid-stream: fifo_count=5, pend=4'b0110, assert reset one cycle -> next cycle out_valid=0, fifo_count=0, drop_count=0; a fresh request after reset emerges with latency 2.
